// File: rtl/lcd_pkg.sv
// Shared command bytes, sequencer states and step counts for the LCD blocks.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int INIT_STEPS    = 4;
    localparam int REFRESH_STEPS = 34;

    typedef enum logic [2:0] {
        S_PWR,
        S_ISSUE,
        S_HOLD,
        S_WAIT,
        S_DELAY,
        S_IDLE
    } lcd_seq_state_t;

    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        logic [7:0] cmd;
        unique case (idx)
            2'd0: cmd = LCD_FUNC_SET;
            2'd1: cmd = LCD_DISP_ON;
            2'd2: cmd = LCD_ENTRY;
            2'd3: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: a load of N flags expiry on the Nth enabled cycle.
module lcd_delay_timer #(
    parameter int DLY_W = 20
) (
    input  logic             iCLK,
    input  logic             iLoad,
    input  logic [DLY_W-1:0] iValue,
    input  logic             iEn,
    output logic             oExpire
);

    logic [DLY_W-1:0] count;

    // A zero load would never reach the expiry value, so it runs as one cycle.
    always_ff @(posedge iCLK) begin
        if (iLoad)
            count <= (iValue == '0) ? DLY_W'(1) : iValue;
        else if (iEn && count != '0)
            count <= count - DLY_W'(1);
    end

    assign oExpire = (count == DLY_W'(1));

endmodule

// File: rtl/lcd_text_sequencer.sv
// HD44780 power-up init followed by 2x16 text refreshes from a 32-byte buffer.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_DELAY = 750000,
    parameter int CMD_DELAY     = 2000,
    parameter int CLEAR_DELAY   = 82000,
    parameter int DLY_W         = 20
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iRefresh,
    output logic       oReady,
    output logic       oBusy,
    output logic [4:0] oChar_Addr,
    input  logic [7:0] iChar_Data,
    output logic [7:0] oLCD_Data,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done
);

    lcd_seq_state_t state;
    logic [5:0] step;
    logic initPhase;
    logic pending;

    logic timerLoad;
    logic timerEn;
    logic timerExpire;
    logic [DLY_W-1:0] timerValue;

    logic isClear;
    logic isLine1;
    logic isLine2;
    logic lastInit;
    logic lastRefresh;
    logic issueRs;
    logic [7:0] issueData;
    logic [4:0] nextAddr;

    always_comb begin
        isClear = !oLCD_RS && (oLCD_Data == LCD_CLEAR);
        timerLoad = iRST || (state == S_WAIT && iLCD_Done);
        timerEn = (state == S_PWR) || (state == S_DELAY);
        if (iRST)
            timerValue = DLY_W'(POWERUP_DELAY);
        else if (isClear)
            timerValue = DLY_W'(CLEAR_DELAY);
        else
            timerValue = DLY_W'(CMD_DELAY);
    end

    always_comb begin
        isLine1 = !initPhase && (step == 6'd0);
        isLine2 = !initPhase && (step == 6'd17);
        lastInit = initPhase && (step == 6'(INIT_STEPS - 1));
        lastRefresh = !initPhase && (step == 6'(REFRESH_STEPS - 1));
        nextAddr = (step < 6'd17) ? step[4:0] : 5'(step - 6'd1);
        issueRs = 1'b0;
        issueData = 8'h00;
        unique case (1'b1)
            initPhase: issueData = initCmd(step[1:0]);
            isLine1:   issueData = LCD_LINE1;
            isLine2:   issueData = LCD_LINE2;
            default: begin
                issueRs = 1'b1;
                issueData = iChar_Data;
            end
        endcase
    end

    lcd_delay_timer #(
        .DLY_W(DLY_W)
    ) uTimer (
        .iCLK   (iCLK),
        .iLoad  (timerLoad),
        .iValue (timerValue),
        .iEn    (timerEn),
        .oExpire(timerExpire)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= S_PWR;
            step <= '0;
            initPhase <= 1'b1;
            pending <= 1'b0;
            oReady <= 1'b0;
            oBusy <= 1'b1;
            oChar_Addr <= '0;
            oLCD_Data <= 8'h00;
            oLCD_RS <= 1'b0;
            oLCD_Start <= 1'b0;
        end else begin
            if (iRefresh && state != S_IDLE)
                pending <= 1'b1;
            unique case (state)
                S_PWR: begin
                    if (timerExpire) begin
                        step <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    oLCD_Data <= issueData;
                    oLCD_RS <= issueRs;
                    oLCD_Start <= 1'b1;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    oLCD_Start <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iLCD_Done)
                        state <= S_DELAY;
                end
                S_DELAY: begin
                    if (timerExpire) begin
                        if (lastInit) begin
                            initPhase <= 1'b0;
                            step <= '0;
                            oReady <= 1'b1;
                            state <= S_ISSUE;
                        end else if (lastRefresh) begin
                            oBusy <= pending || iRefresh;
                            state <= S_IDLE;
                        end else begin
                            step <= step + 6'd1;
                            state <= S_ISSUE;
                            // Address leads the issue cycle so buffer data has settled.
                            if (!initPhase && step != 6'd16)
                                oChar_Addr <= nextAddr;
                        end
                    end
                end
                S_IDLE: begin
                    if (iRefresh || pending) begin
                        pending <= 1'b0;
                        oBusy <= 1'b1;
                        step <= '0;
                        state <= S_ISSUE;
                    end else begin
                        oBusy <= 1'b0;
                    end
                end
                default: state <= S_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed and randomized checks of lcd_text_sequencer against a byte-stream model.
module tb_lcd_text_sequencer;

    localparam int PWR = 20;
    localparam int CMD = 4;
    localparam int CLR = 10;
    localparam int DONE_LAT = 18;

    typedef struct {
        logic [8:0] word;
        int cyc;
        logic ready;
    } ev_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic iRefresh = 1'b0;
    logic iLCD_Done;
    logic oReady;
    logic oBusy;
    logic oLCD_RS;
    logic oLCD_Start;
    logic [4:0] oChar_Addr;
    logic [7:0] oLCD_Data;
    logic [7:0] iChar_Data;
    logic [7:0] buffer[32];

    int nAssert = 0;
    int nFail = 0;
    int cyc = 0;
    int doneCnt;
    logic modelPrev;

    ev_t startQ[$];
    logic [8:0] expQ[$];
    int stCyc[80];
    logic stReady[80];

    logic prevStart = 1'b0;
    logic inWrite = 1'b0;
    logic [8:0] capWord = '0;

    lcd_text_sequencer #(
        .POWERUP_DELAY(PWR),
        .CMD_DELAY    (CMD),
        .CLEAR_DELAY  (CLR),
        .DLY_W        (20)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iRefresh  (iRefresh),
        .oReady    (oReady),
        .oBusy     (oBusy),
        .oChar_Addr(oChar_Addr),
        .iChar_Data(iChar_Data),
        .oLCD_Data (oLCD_Data),
        .oLCD_RS   (oLCD_RS),
        .oLCD_Start(oLCD_Start),
        .iLCD_Done (iLCD_Done)
    );

    assign iChar_Data = buffer[oChar_Addr];

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Write controller: done drops after the start edge, returns DONE_LAT later.
    always @(posedge iCLK) begin
        if (iRST) begin
            iLCD_Done <= 1'b0;
            doneCnt <= 0;
            modelPrev <= 1'b0;
        end else begin
            modelPrev <= oLCD_Start;
            if (oLCD_Start && !modelPrev) begin
                iLCD_Done <= 1'b0;
                doneCnt <= DONE_LAT - 1;
            end else if (doneCnt != 0) begin
                doneCnt <= doneCnt - 1;
                if (doneCnt == 1)
                    iLCD_Done <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (prevStart)
            check("start_width", int'(oLCD_Start), 0);
        if (inWrite && iLCD_Done) begin
            check("data_stable", int'({oLCD_RS, oLCD_Data}), int'(capWord));
            inWrite <= 1'b0;
        end
        if (oLCD_Start && !prevStart) begin
            startQ.push_back('{word: {oLCD_RS, oLCD_Data}, cyc: cyc, ready: oReady});
            capWord <= {oLCD_RS, oLCD_Data};
            inWrite <= 1'b1;
        end
        prevStart <= oLCD_Start;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge iCLK);
            #1;
        end
    endtask

    task automatic loadText(input string s);
        for (int i = 0; i < 32; i++)
            buffer[i] = s[i];
    endtask

    task automatic addInit();
        expQ.push_back({1'b0, 8'h38});
        expQ.push_back({1'b0, 8'h0C});
        expQ.push_back({1'b0, 8'h06});
        expQ.push_back({1'b0, 8'h01});
    endtask

    task automatic addRefresh();
        expQ.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++)
            expQ.push_back({1'b1, buffer[i]});
        expQ.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++)
            expQ.push_back({1'b1, buffer[i]});
    endtask

    task automatic expectN(input string tag, input int n);
        int k = 0;
        int waited;
        ev_t ev;
        while (k < n && expQ.size() > 0) begin
            waited = 0;
            while (startQ.size() == 0 && waited < 600) begin
                tick(1);
                waited++;
            end
            if (startQ.size() == 0) begin
                check({tag, "_timeout"}, 0, 1);
                expQ.delete();
                return;
            end
            ev = startQ.pop_front();
            check(tag, int'(ev.word), int'(expQ.pop_front()));
            stCyc[k] = ev.cyc;
            stReady[k] = ev.ready;
            k++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int waited = 0;
        while (oBusy && waited < 3000) begin
            tick(1);
            waited++;
        end
        check(tag, int'(oBusy), 0);
    endtask

    task automatic pulse();
        iRefresh = 1'b1;
        tick(1);
        iRefresh = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_ready"}, int'(oReady), 0);
        check({tag, "_busy"}, int'(oBusy), 1);
        check({tag, "_start"}, int'(oLCD_Start), 0);
        check({tag, "_data"}, int'(oLCD_Data), 0);
        check({tag, "_rs"}, int'(oLCD_RS), 0);
        check({tag, "_addr"}, int'(oChar_Addr), 0);
    endtask

    initial begin
        int relCyc;
        int c[4];
        int r0Cyc;
        logic r0Ready;
        logic clrReady;

        loadText("HELLO WORLD     DCLAB 2019      ");
        tick(3);
        checkReset("rst");
        iRST = 1'b0;
        relCyc = cyc;

        addInit();
        expectN("init", 4);
        for (int i = 0; i < 4; i++)
            c[i] = stCyc[i];
        clrReady = stReady[3];
        check("first_start_lat", stCyc[0] - relCyc, PWR + 1);

        addRefresh();
        expectN("auto_refresh", 34);
        r0Cyc = stCyc[0];
        r0Ready = stReady[0];
        check("cmd_gap", c[1] - c[0], DONE_LAT + CMD + 2);
        check("cmd_gap_eq", c[2] - c[1], c[1] - c[0]);
        check("clear_gap_extra", (r0Cyc - c[3]) - (c[3] - c[2]), CLR - CMD);
        check("ready_at_clear", int'(clrReady), 0);
        check("ready_at_refresh", int'(r0Ready), 1);
        waitIdle("auto_idle");
        check("ready_hold", int'(oReady), 1);

        buffer[5] = "X";
        tick(7);
        check("idle_busy", int'(oBusy), 0);
        pulse();
        check("refresh_busy", int'(oBusy), 1);
        addRefresh();
        expectN("refresh_x", 34);
        waitIdle("refresh_x_idle");

        pulse();
        addRefresh();
        addRefresh();
        repeat (3) begin
            tick($urandom_range(5, 40));
            pulse();
        end
        expectN("multi", 68);
        waitIdle("multi_idle");
        tick(300);
        check("multi_no_extra", startQ.size(), 0);
        check("multi_busy", int'(oBusy), 0);

        for (int i = 0; i < 32; i++)
            buffer[i] = 8'($urandom_range(32, 126));
        tick($urandom_range(1, 20));
        pulse();
        addRefresh();
        expectN("random", 34);
        waitIdle("random_idle");

        pulse();
        addRefresh();
        expectN("pre_reset", 4);
        tick(5);
        iRST = 1'b1;
        tick(1);
        checkReset("mid_rst");
        iRST = 1'b0;
        relCyc = cyc;
        expQ.delete();
        check("no_stray", startQ.size(), 0);
        addInit();
        expectN("reinit", 4);
        check("reinit_lat", stCyc[0] - relCyc, PWR + 1);
        addRefresh();
        expectN("reinit_refresh", 34);
        waitIdle("reinit_idle");
        tick(100);
        check("final_quiet", startQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
